// File: rtl/cpu_trace_capture.sv
// Instruction-trace recorder: circular {pc, ir} capture with PC breakpoint, post-trigger window and oldest-first readout.
// Optional RAM-write tracing is enabled by defining TRACE_RAMWR_EN (adds a tag bit to each entry).
module cpu_trace_capture #(
    parameter int DATA_WIDTH  = 8,
    parameter int STATE_WIDTH = 6,
    parameter int DEPTH       = 16,
    parameter int FETCH_STATE = 0,
    parameter int POST_COUNT  = 4,
`ifdef TRACE_RAMWR_EN
    localparam int ENTRY_W    = 2*DATA_WIDTH + 1,
`else
    localparam int ENTRY_W    = 2*DATA_WIDTH,
`endif
    localparam int CNT_W      = $clog2(DEPTH+1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   arm,
    input  logic                   force_stop,
    input  logic                   break_en,
    input  logic [DATA_WIDTH-1:0]  break_pc,
    input  logic [DATA_WIDTH-1:0]  pc,
    input  logic [DATA_WIDTH-1:0]  ir,
    input  logic [STATE_WIDTH-1:0] state,
`ifdef TRACE_RAMWR_EN
    input  logic                   ram_write,
    input  logic [DATA_WIDTH-1:0]  ram_address,
    input  logic [DATA_WIDTH-1:0]  ram_data_in,
`endif
    input  logic                   rd_en,
    output logic [ENTRY_W-1:0]     rd_data,
    output logic                   rd_valid,
    output logic [CNT_W-1:0]       count,
    output logic                   overflow,
    output logic                   triggered,
    output logic                   done
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} fsm_e;

    fsm_e                   fsm_q;
    logic [STATE_WIDTH-1:0] prev_state_q;
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [PTR_W-1:0]       post_q;
    logic [CNT_W-1:0]       count_q;
    logic [ENTRY_W-1:0]     rd_data_q;
    logic                   rd_valid_q;
    logic                   overflow_q;
    logic                   triggered_q;
    logic                   done_q;
    logic [ENTRY_W-1:0]     mem_q [DEPTH];

    logic                   fetch_ev;
    logic                   capturing;
    logic                   bp_hit;
    logic                   wr_en;
    logic [ENTRY_W-1:0]     wr_entry;

    // A fetch is recognised on entry into the fetch state, so a multi-cycle fetch records once.
    assign fetch_ev  = (state == STATE_WIDTH'(FETCH_STATE)) &&
                       (prev_state_q != STATE_WIDTH'(FETCH_STATE));
    assign capturing = ((fsm_q == ARMED) || (fsm_q == POST)) && !arm;
    assign bp_hit    = fetch_ev && break_en && (pc == break_pc);

`ifdef TRACE_RAMWR_EN
    logic               ram_pend_q;
    logic [ENTRY_W-1:0] ram_pend_entry_q;
    logic               ram_stash;

    // Fetch wins the write port; a colliding RAM write is replayed in the following cycle.
    always_comb begin
        wr_en     = 1'b0;
        wr_entry  = {1'b0, pc, ir};
        ram_stash = 1'b0;
        if (capturing) begin
            if (fetch_ev) begin
                wr_en     = 1'b1;
                ram_stash = ram_write;
            end else if (ram_pend_q) begin
                wr_en     = 1'b1;
                wr_entry  = ram_pend_entry_q;
                ram_stash = ram_write;
            end else if (ram_write) begin
                wr_en     = 1'b1;
                wr_entry  = {1'b1, ram_address, ram_data_in};
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ram_pend_q       <= 1'b0;
            ram_pend_entry_q <= '0;
        end else begin
            ram_pend_q <= ram_stash;
            if (ram_stash) begin
                ram_pend_entry_q <= {1'b1, ram_address, ram_data_in};
            end
        end
    end
`else
    assign wr_en    = capturing && fetch_ev;
    assign wr_entry = {pc, ir};
`endif

    // NOTE: the trace array has no reset; count and pointers alone define which entries are valid.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_q        <= IDLE;
            prev_state_q <= '1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            post_q       <= '0;
            count_q      <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            overflow_q   <= 1'b0;
            triggered_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            prev_state_q <= state;
            rd_valid_q   <= 1'b0;
            if (arm) begin
                fsm_q       <= ARMED;
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
                count_q     <= '0;
                overflow_q  <= 1'b0;
                triggered_q <= 1'b0;
                done_q      <= 1'b0;
            end else begin
                case (fsm_q)
                    ARMED, POST: begin
                        if (wr_en) begin
                            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                            if (count_q == CNT_W'(DEPTH)) begin
                                rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
                                overflow_q <= 1'b1;
                            end else begin
                                count_q <= count_q + CNT_W'(1);
                            end
                        end
                        if (fsm_q == ARMED && bp_hit) begin
                            triggered_q <= 1'b1;
                        end
                        if (force_stop) begin
                            fsm_q  <= DONE;
                            done_q <= 1'b1;
                        end else if (fsm_q == ARMED && bp_hit) begin
                            if (POST_COUNT == 0) begin
                                fsm_q  <= DONE;
                                done_q <= 1'b1;
                            end else begin
                                post_q <= PTR_W'(POST_COUNT);
                                fsm_q  <= POST;
                            end
                        end else if (fsm_q == POST && fetch_ev) begin
                            post_q <= post_q - PTR_W'(1);
                            if (post_q == PTR_W'(1)) begin
                                fsm_q  <= DONE;
                                done_q <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        if (rd_en && count_q != '0) begin
                            rd_data_q  <= mem_q[rd_ptr_q];
                            rd_valid_q <= 1'b1;
                            rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
                            count_q    <= count_q - CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign triggered = triggered_q;
    assign done      = done_q;

endmodule

// File: tb/tb_cpu_trace_capture.sv
// Scoreboard bench for cpu_trace_capture: two instances (POST_COUNT=2 and POST_COUNT=0) share stimulus;
// expected readout entries are queued by the stimulus and popped by per-instance monitors on rd_valid.
module tb_cpu_trace_capture;

    logic       clock;
    logic       reset;
    logic       arm;
    logic       force_stop;
    logic       break_en;
    logic [7:0] break_pc;
    logic [7:0] pc;
    logic [7:0] ir;
    logic [5:0] state;
    logic       rd_en_a, rd_en_b;

    logic [15:0] rd_data_a, rd_data_b;
    logic        rd_valid_a, rd_valid_b;
    logic [2:0]  count_a, count_b;
    logic        overflow_a, overflow_b;
    logic        triggered_a, triggered_b;
    logic        done_a, done_b;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_a[$];
    logic [15:0] exp_b[$];

    cpu_trace_capture #(
        .DATA_WIDTH(8), .STATE_WIDTH(6), .DEPTH(4), .FETCH_STATE(1), .POST_COUNT(2)
    ) dut_a (
        .clock(clock), .reset(reset), .arm(arm), .force_stop(force_stop),
        .break_en(break_en), .break_pc(break_pc), .pc(pc), .ir(ir), .state(state),
        .rd_en(rd_en_a), .rd_data(rd_data_a), .rd_valid(rd_valid_a), .count(count_a),
        .overflow(overflow_a), .triggered(triggered_a), .done(done_a)
    );

    cpu_trace_capture #(
        .DATA_WIDTH(8), .STATE_WIDTH(6), .DEPTH(4), .FETCH_STATE(1), .POST_COUNT(0)
    ) dut_b (
        .clock(clock), .reset(reset), .arm(arm), .force_stop(force_stop),
        .break_en(break_en), .break_pc(break_pc), .pc(pc), .ir(ir), .state(state),
        .rd_en(rd_en_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b), .count(count_b),
        .overflow(overflow_b), .triggered(triggered_b), .done(done_b)
    );

    initial begin
        clock = 1'b0;
        #30;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (rd_valid_a) begin
            if (exp_a.size() == 0) check("rd_valid_a unexpected", 32'd1, 32'd0);
            else check("rd_data_a", {16'h0, rd_data_a}, {16'h0, exp_a.pop_front()});
        end
        if (rd_valid_b) begin
            if (exp_b.size() == 0) check("rd_valid_b unexpected", 32'd1, 32'd0);
            else check("rd_data_b", {16'h0, rd_data_b}, {16'h0, exp_b.pop_front()});
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic fetch(input logic [7:0] p, input logic [7:0] i);
        pc    = p;
        ir    = i;
        state = 6'd1;
        tick();
        state = 6'd0;
        tick();
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic stop();
        force_stop = 1'b1;
        tick();
        force_stop = 1'b0;
    endtask

    task automatic pop_a();
        rd_en_a = 1'b1;
        tick();
        rd_en_a = 1'b0;
        tick();
    endtask

    task automatic pop_b();
        rd_en_b = 1'b1;
        tick();
        rd_en_b = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b0; arm = 1'b0; force_stop = 1'b0; break_en = 1'b0;
        break_pc = 8'h00; pc = 8'h00; ir = 8'h00; state = 6'd0;
        rd_en_a = 1'b0; rd_en_b = 1'b0;

        // 1: asynchronous reset before any clock edge
        #5 reset = 1'b1;
        #15;
        check("reset done",      {31'd0, done_a},      32'd0);
        check("reset count",     {29'd0, count_a},     32'd0);
        check("reset overflow",  {31'd0, overflow_a},  32'd0);
        check("reset triggered", {31'd0, triggered_a}, 32'd0);
        check("reset rd_valid",  {31'd0, rd_valid_a},  32'd0);
        check("reset rd_data",   {16'd0, rd_data_a},   32'd0);
        #5 reset = 1'b0;
        tick();

        // 2: three fetches, force_stop, readout and an empty pop
        do_arm();
        fetch(8'h00, 8'h10);
        fetch(8'h01, 8'h11);
        fetch(8'h02, 8'h12);
        stop();
        check("t2 done",  {31'd0, done_a},  32'd1);
        check("t2 count", {29'd0, count_a}, 32'd3);
        check("t2 triggered", {31'd0, triggered_a}, 32'd0);
        exp_a.push_back(16'h0010);
        exp_a.push_back(16'h0111);
        exp_a.push_back(16'h0212);
        repeat (3) pop_a();
        check("t2 count after pops", {29'd0, count_a}, 32'd0);
        rd_en_a = 1'b1;
        tick();
        rd_en_a = 1'b0;
        check("t2 empty pop rd_valid", {31'd0, rd_valid_a}, 32'd0);
        check("t2 rd_data held", {16'd0, rd_data_a}, 32'h0212);
        tick();

        // 3: breakpoint at 0x05 with two post-trigger fetches and wrap
        break_en = 1'b1;
        break_pc = 8'h05;
        do_arm();
        for (int i = 0; i < 8; i++) begin
            fetch(8'(i), 8'(8'h10 + i));
            if (i == 5) begin
                check("t3 triggered at 0x05", {31'd0, triggered_a}, 32'd1);
                check("t3 not done at 0x05", {31'd0, done_a}, 32'd0);
            end
            if (i == 6) check("t3 not done at 0x06", {31'd0, done_a}, 32'd0);
        end
        check("t3 done",     {31'd0, done_a},     32'd1);
        check("t3 overflow", {31'd0, overflow_a}, 32'd1);
        check("t3 count",    {29'd0, count_a},    32'd4);
        exp_a.push_back(16'h0414);
        exp_a.push_back(16'h0515);
        exp_a.push_back(16'h0616);
        exp_a.push_back(16'h0717);
        repeat (4) pop_a();

        // 4: POST_COUNT = 0 instance stops right after the trigger entry
        break_pc = 8'h03;
        do_arm();
        fetch(8'h00, 8'h10);
        fetch(8'h01, 8'h11);
        fetch(8'h02, 8'h12);
        pc = 8'h03; ir = 8'h13; state = 6'd1;
        tick();
        check("t4 b done next cycle", {31'd0, done_b}, 32'd1);
        check("t4 b triggered", {31'd0, triggered_b}, 32'd1);
        check("t4 a still in post", {31'd0, done_a}, 32'd0);
        state = 6'd0;
        tick();
        check("t4 b count", {29'd0, count_b}, 32'd4);
        check("t4 b overflow", {31'd0, overflow_b}, 32'd0);
        exp_b.push_back(16'h0010);
        exp_b.push_back(16'h0111);
        exp_b.push_back(16'h0212);
        exp_b.push_back(16'h0313);
        repeat (4) pop_b();

        // 5: a held fetch state records once; an event in the arm cycle is dropped
        break_en = 1'b0;
        do_arm();
        pc = 8'h20; ir = 8'h30; state = 6'd1;
        repeat (5) tick();
        state = 6'd0;
        tick();
        stop();
        check("t5 held fetch count", {29'd0, count_a}, 32'd1);
        exp_a.push_back(16'h2030);
        pop_a();
        arm = 1'b1; pc = 8'h21; ir = 8'h31; state = 6'd1;
        tick();
        arm = 1'b0;
        tick();
        state = 6'd0;
        tick();
        check("t5 arm-cycle event count", {29'd0, count_a}, 32'd0);
        check("t5 armed not done", {31'd0, done_a}, 32'd0);

        // 6: asynchronous reset while in POST
        break_en = 1'b1;
        break_pc = 8'h40;
        do_arm();
        fetch(8'h40, 8'h50);
        fetch(8'h41, 8'h51);
        check("t6 triggered", {31'd0, triggered_a}, 32'd1);
        check("t6 count before reset", {29'd0, count_a}, 32'd2);
        #2 reset = 1'b1;
        #1;
        check("t6 async count",     {29'd0, count_a},     32'd0);
        check("t6 async done",      {31'd0, done_a},      32'd0);
        check("t6 async triggered", {31'd0, triggered_a}, 32'd0);
        check("t6 async overflow",  {31'd0, overflow_a},  32'd0);
        #2 reset = 1'b0;
        tick();
        rd_en_a = 1'b1;
        tick();
        rd_en_a = 1'b0;
        check("t6 pop after reset rd_valid", {31'd0, rd_valid_a}, 32'd0);
        tick();

        check("scoreboard a drained", exp_a.size(), 32'd0);
        check("scoreboard b drained", exp_b.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
